// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute sequencer for the program counter.
// It latches each fetched instruction into the IR, decodes BR/JMP/HALT and
// drives the PC enable and branch/jump selects. It also owns halt, stall
// and fetch-timeout handling.
//
// Optional build macro: SINGLE_STEP_EN. When defined, the ports
// step_mode_pi and step_pi are added. With step_mode_pi=1, EXEC retires an
// instruction only in a cycle where step_pi=1.
//
// State table:
//   state      | meaning
//   ST_FETCH   | wait for imem_ready_pi, count timeout
//   ST_EXEC    | decode IR, drive PC controls, retire instruction
//   ST_HALTED  | parked after HALT or fetch timeout, wait for resume
//
// Ports:
//   clk_pi, reset_pi (sync, active-high), clk_en_pi (global freeze)
//   imem_ready_pi, instr_pi[15:0]   instruction memory handshake
//   branch_cond_pi, stall_pi, resume_pi
//   pc_en_po, branch_taken_po, jump_taken_po   combinational PC controls
//   branch_immediate_po[5:0], jump_immediate_po[11:0], ir_po[15:0]
//   ir_valid_po, halted_po, fetch_error_po, retired_count_po[CNT_W-1:0]
module pc_sequencer #(
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 16
) (
  input  logic             clk_pi,
  input  logic             reset_pi,
  input  logic             clk_en_pi,
  input  logic             imem_ready_pi,
  input  logic [15:0]      instr_pi,
  input  logic             branch_cond_pi,
  input  logic             stall_pi,
  input  logic             resume_pi,
  output logic             pc_en_po,
  output logic             branch_taken_po,
  output logic [5:0]       branch_immediate_po,
  output logic             jump_taken_po,
  output logic [11:0]      jump_immediate_po,
  output logic [15:0]      ir_po,
  output logic             ir_valid_po,
  output logic             halted_po,
  output logic             fetch_error_po,
  output logic [CNT_W-1:0] retired_count_po
`ifdef SINGLE_STEP_EN
  ,
  input  logic             step_mode_pi,
  input  logic             step_pi
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_EXEC   = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Timeout fires on the edge that closes the FETCH_TIMEOUT-th waiting cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     state;
  logic [7:0] to_cnt;
  logic       is_br, is_jmp, is_halt;
  logic       step_ok;
  logic       retire;

  assign is_br   = (ir_po[15:12] == OP_BR);
  assign is_jmp  = (ir_po[15:12] == OP_JMP);
  assign is_halt = (ir_po[15:12] == OP_HALT);

`ifdef SINGLE_STEP_EN
  assign step_ok = !step_mode_pi || step_pi;
`else
  assign step_ok = 1'b1;
`endif

  // An EXEC cycle retires only when it is neither stalled nor step-gated.
  assign retire = (state == ST_EXEC) && !stall_pi && step_ok;

  assign branch_immediate_po = ir_po[5:0];
  assign jump_immediate_po   = ir_po[11:0];

  // The PC controls are combinational so that the PC updates on the same
  // edge that leaves EXEC (or HALTED on a resume).
  always_comb begin
    pc_en_po        = 1'b0;
    branch_taken_po = 1'b0;
    jump_taken_po   = 1'b0;
    if (!reset_pi && clk_en_pi) begin
      if (retire && !is_halt) begin
        pc_en_po        = 1'b1;
        branch_taken_po = is_br && branch_cond_pi;
        jump_taken_po   = is_jmp;
      end else if (state == ST_HALTED && resume_pi && !fetch_error_po) begin
        pc_en_po = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state            <= ST_FETCH;
      to_cnt           <= 8'd0;
      ir_po            <= 16'h0000;
      ir_valid_po      <= 1'b0;
      halted_po        <= 1'b0;
      fetch_error_po   <= 1'b0;
      retired_count_po <= '0;
    end else if (clk_en_pi) begin
      case (state)
        ST_FETCH: begin
          // Ready on the timeout cycle takes precedence over the error.
          if (imem_ready_pi) begin
            ir_po       <= instr_pi;
            ir_valid_po <= 1'b1;
            to_cnt      <= 8'd0;
            state       <= ST_EXEC;
          end else if (to_cnt == TIMEOUT_LAST) begin
            fetch_error_po <= 1'b1;
            halted_po      <= 1'b1;
            to_cnt         <= 8'd0;
            state          <= ST_HALTED;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        ST_EXEC: begin
          if (retire) begin
            ir_valid_po      <= 1'b0;
            retired_count_po <= retired_count_po + CNT_W'(1);
            if (is_halt) begin
              halted_po <= 1'b1;
              state     <= ST_HALTED;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          // A fetch error is sticky, so only a reset leaves HALTED after one.
          if (resume_pi && !fetch_error_po) begin
            halted_po <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int TO = 15;
  localparam int CW = 4;

  logic          clk_pi = 1'b0;
  logic          reset_pi = 1'b1;
  logic          clk_en_pi = 1'b1;
  logic          imem_ready_pi = 1'b0;
  logic [15:0]   instr_pi = 16'h0000;
  logic          branch_cond_pi = 1'b0;
  logic          stall_pi = 1'b0;
  logic          resume_pi = 1'b0;
  logic          pc_en_po, branch_taken_po, jump_taken_po;
  logic [5:0]    branch_immediate_po;
  logic [11:0]   jump_immediate_po;
  logic [15:0]   ir_po;
  logic          ir_valid_po, halted_po, fetch_error_po;
  logic [CW-1:0] retired_count_po;
`ifdef SINGLE_STEP_EN
  logic          step_mode_pi = 1'b0;
  logic          step_pi = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer #(.FETCH_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_pi(clk_pi), .reset_pi(reset_pi), .clk_en_pi(clk_en_pi),
    .imem_ready_pi(imem_ready_pi), .instr_pi(instr_pi),
    .branch_cond_pi(branch_cond_pi), .stall_pi(stall_pi), .resume_pi(resume_pi),
    .pc_en_po(pc_en_po), .branch_taken_po(branch_taken_po),
    .branch_immediate_po(branch_immediate_po), .jump_taken_po(jump_taken_po),
    .jump_immediate_po(jump_immediate_po), .ir_po(ir_po), .ir_valid_po(ir_valid_po),
    .halted_po(halted_po), .fetch_error_po(fetch_error_po),
    .retired_count_po(retired_count_po)
`ifdef SINGLE_STEP_EN
    , .step_mode_pi(step_mode_pi), .step_pi(step_pi)
`endif
  );

  always #5 clk_pi = ~clk_pi;

  task automatic tick();
    @(posedge clk_pi);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ir"}, 32'(ir_po), 32'h0);
    chk({tag, "_irv"}, 32'(ir_valid_po), 32'h0);
    chk({tag, "_halt"}, 32'(halted_po), 32'h0);
    chk({tag, "_ferr"}, 32'(fetch_error_po), 32'h0);
    chk({tag, "_ret"}, 32'(retired_count_po), 32'h0);
    chk({tag, "_pcen"}, 32'(pc_en_po), 32'h0);
  endtask

  initial begin
    // Reset with clk_en low and ready high: reset still wins.
    clk_en_pi = 1'b0; imem_ready_pi = 1'b1; instr_pi = 16'hFFFF;
    tick(); tick();
    #1; chk_reset_vals("rst");
    clk_en_pi = 1'b1;

    // 1: sequential stream, pc_en every second cycle, 4 retired in 8 cycles
    reset_pi = 1'b0; instr_pi = 16'h0001;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("seq_pcen", 32'(pc_en_po), 32'(i % 2));
      chk("seq_taken", {30'd0, branch_taken_po, jump_taken_po}, 32'h0);
      tick();
    end
    chk("seq_ret", 32'(retired_count_po), 32'd4);

    // 2: branch taken then not taken
    instr_pi = 16'hC03E; branch_cond_pi = 1'b1;
    tick();
    #1;
    chk("br_ir", 32'(ir_po), 32'hC03E);
    chk("br_irv", 32'(ir_valid_po), 32'h1);
    chk("br_pcen", 32'(pc_en_po), 32'h1);
    chk("br_taken1", 32'(branch_taken_po), 32'h1);
    chk("br_imm", 32'(branch_immediate_po), 32'h3E);
    chk("br_jmp", 32'(jump_taken_po), 32'h0);
    branch_cond_pi = 1'b0; #1;
    chk("br_taken0", 32'(branch_taken_po), 32'h0);
    chk("br_pcen0", 32'(pc_en_po), 32'h1);
    tick();
    chk("br_ret", 32'(retired_count_po), 32'd5);
    chk("br_irv0", 32'(ir_valid_po), 32'h0);

    // 3: jump held by a 3-cycle stall
    instr_pi = 16'hD800;
    tick();
    stall_pi = 1'b1; imem_ready_pi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pcen", 32'(pc_en_po), 32'h0);
      chk("stall_jmp", 32'(jump_taken_po), 32'h0);
      tick();
    end
    stall_pi = 1'b0; #1;
    chk("jmp_pcen", 32'(pc_en_po), 32'h1);
    chk("jmp_taken", 32'(jump_taken_po), 32'h1);
    chk("jmp_imm", 32'(jump_immediate_po), 32'h800);
    chk("jmp_br", 32'(branch_taken_po), 32'h0);
    tick();
    chk("jmp_ret", 32'(retired_count_po), 32'd6);

    // 4: HALT, park 10 cycles, resume gives a single pc_en pulse
    imem_ready_pi = 1'b1; instr_pi = 16'hF000;
    tick();
    #1; chk("halt_exec_pcen", 32'(pc_en_po), 32'h0);
    imem_ready_pi = 1'b0;
    tick();
    chk("halt_ret", 32'(retired_count_po), 32'd7);
    chk("halt_irv", 32'(ir_valid_po), 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("halted", 32'(halted_po), 32'h1);
      chk("halted_pcen", 32'(pc_en_po), 32'h0);
      tick();
    end
    resume_pi = 1'b1; #1;
    chk("resume_pcen", 32'(pc_en_po), 32'h1);
    chk("resume_taken", {30'd0, branch_taken_po, jump_taken_po}, 32'h0);
    tick();
    resume_pi = 1'b0; #1;
    chk("resume_halt", 32'(halted_po), 32'h0);
    chk("resume_pcen_after", 32'(pc_en_po), 32'h0);

    // 5: fetch timeout after exactly TO waiting cycles
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_early_err", 32'(fetch_error_po), 32'h0);
    chk("to_early_halt", 32'(halted_po), 32'h0);
    tick();
    chk("to_err", 32'(fetch_error_po), 32'h1);
    chk("to_halt", 32'(halted_po), 32'h1);
    resume_pi = 1'b1; #1;
    chk("to_resume_pcen", 32'(pc_en_po), 32'h0);
    tick();
    resume_pi = 1'b0;
    chk("to_resume_halt", 32'(halted_po), 32'h1);
    chk("to_resume_err", 32'(fetch_error_po), 32'h1);
    reset_pi = 1'b1;
    tick();
    reset_pi = 1'b0; #1;
    chk_reset_vals("to_rst");

    // Ready on the timeout cycle wins
    for (int i = 0; i < TO - 1; i++) tick();
    imem_ready_pi = 1'b1; instr_pi = 16'h0001;
    tick();
    chk("to_edge_err", 32'(fetch_error_po), 32'h0);
    chk("to_edge_irv", 32'(ir_valid_po), 32'h1);
    #1; chk("to_edge_pcen", 32'(pc_en_po), 32'h1);

    // Reset mid-EXEC
    reset_pi = 1'b1; #1;
    chk("rst_exec_pcen", 32'(pc_en_po), 32'h0);
    tick();
    reset_pi = 1'b0; imem_ready_pi = 1'b0; #1;
    chk_reset_vals("rst_exec");

    // 6: clk_en low freezes EXEC
    imem_ready_pi = 1'b1; instr_pi = 16'hD123;
    tick();
    clk_en_pi = 1'b0; #1;
    chk("cke_pcen", 32'(pc_en_po), 32'h0);
    chk("cke_jmp", 32'(jump_taken_po), 32'h0);
    tick(); tick();
    chk("cke_irv", 32'(ir_valid_po), 32'h1);
    chk("cke_ir", 32'(ir_po), 32'hD123);
    chk("cke_ret", 32'(retired_count_po), 32'd0);
    clk_en_pi = 1'b1; #1;
    chk("cke_pcen1", 32'(pc_en_po), 32'h1);
    chk("cke_jmp1", 32'(jump_taken_po), 32'h1);
    chk("cke_jimm", 32'(jump_immediate_po), 32'h123);
    tick();
    chk("cke_ret1", 32'(retired_count_po), 32'd1);

    // Retired counter wraps: 15 more retirements take 1 -> 0 (CNT_W=4)
    instr_pi = 16'h0001;
    for (int i = 0; i < 30; i++) tick();
    chk("wrap_ret", 32'(retired_count_po), 32'd0);

`ifdef SINGLE_STEP_EN
    step_mode_pi = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("step_hold_pcen", 32'(pc_en_po), 32'h0);
      tick();
    end
    chk("step_hold_irv", 32'(ir_valid_po), 32'h1);
    step_pi = 1'b1; #1;
    chk("step_pcen", 32'(pc_en_po), 32'h1);
    tick();
    step_pi = 1'b0; step_mode_pi = 1'b0;
    chk("step_ret", 32'(retired_count_po), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
